// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port screen RAM between video fetch,
// CPU reads and posted CPU writes. Video has absolute priority and fixed
// latency; CPU writes go through a small FIFO with read-after-write forwarding.
module vram_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LVL_W      = 3
) (
    input  logic             clk_sys,
    input  logic             nRESET,
    input  logic             vid_req,
    input  logic [14:0]      vid_addr,
    output logic [7:0]       vid_dout,
    output logic             vid_valid,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    input  logic [14:0]      cpu_addr,
    input  logic [7:0]       cpu_din,
    output logic [7:0]       cpu_dout,
    output logic             cpu_rdy,
    output logic             cpu_busy,
    output logic [14:0]      ram_addr,
    output logic             ram_we,
    output logic [7:0]       ram_din,
    input  logic [7:0]       ram_dout,
    output logic [LVL_W-1:0] fifo_level,
    output logic             wovf
);

    localparam int unsigned PTR_W = LVL_W - 1;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_VID  = 2'd1,
        SLOT_RD   = 2'd2,
        SLOT_WR   = 2'd3
    } slot_t;

    logic [14:0]      fifo_addr [FIFO_DEPTH];
    logic [7:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    slot_t            slot_q;
    slot_t            slot_d1_q;
    slot_t            grant;
    logic             rd_wait_q;
    logic [14:0]      rd_addr_q;
    logic             rd_pending_q;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rd_accept;
    logic             rd_miss;
    logic             req_rd;
    logic [14:0]      rd_addr_sel;
    logic             fwd_hit;
    logic [7:0]       fwd_data;
    logic [LVL_W-1:0] level_nxt;
    logic             rd_pending_nxt;

    // FIFO status and request qualification
    assign full        = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty       = (fifo_level == '0);
    assign push        = cpu_wr & ~full;
    assign pop         = (grant == SLOT_WR);
    assign rd_accept   = cpu_rd & ~rd_pending_q;
    assign rd_miss     = rd_accept & ~fwd_hit;
    assign req_rd      = rd_wait_q | rd_miss;
    assign rd_addr_sel = rd_wait_q ? rd_addr_q : cpu_addr;

    // Forwarding search: newest matching FIFO entry, then a same-cycle write
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 8'h00;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((LVL_W'(i) < fifo_level) &&
                (fifo_addr[rd_ptr_q + PTR_W'(i)] == cpu_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data[rd_ptr_q + PTR_W'(i)];
            end
        end
        // read and write share cpu_addr, so an accepted write is always the newest match
        if (push) begin
            fwd_hit  = 1'b1;
            fwd_data = cpu_din;
        end
    end

    // Slot priority: video, forced drain when full, CPU read, opportunistic drain
    always_comb begin
        grant = SLOT_IDLE;
        if (vid_req) begin
            grant = SLOT_VID;
        end else if (full) begin
            grant = SLOT_WR;
        end else if (req_rd) begin
            grant = SLOT_RD;
        end else if (!empty) begin
            grant = SLOT_WR;
        end
    end

    // Next FIFO level and read-pending flag
    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
        rd_pending_nxt = rd_pending_q;
        if (rd_miss) begin
            rd_pending_nxt = 1'b1;
        end else if (slot_d1_q == SLOT_RD) begin
            rd_pending_nxt = 1'b0;
        end
    end

    // FIFO storage (contents need no reset; validity comes from the level)
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= cpu_addr;
            fifo_data[wr_ptr_q] <= cpu_din;
        end
    end

    // Slot state, RAM port, FIFO pointers and registered outputs
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            slot_q       <= SLOT_IDLE;
            slot_d1_q    <= SLOT_IDLE;
            rd_wait_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_level   <= '0;
            ram_addr     <= '0;
            ram_we       <= 1'b0;
            ram_din      <= '0;
            vid_dout     <= '0;
            vid_valid    <= 1'b0;
            cpu_dout     <= '0;
            cpu_rdy      <= 1'b0;
            cpu_busy     <= 1'b0;
            wovf         <= 1'b0;
        end else begin
            slot_q    <= grant;
            slot_d1_q <= slot_q;
            ram_we    <= (grant == SLOT_WR);

            case (grant)
                SLOT_VID: ram_addr <= vid_addr;
                SLOT_RD:  ram_addr <= rd_addr_sel;
                SLOT_WR: begin
                    ram_addr <= fifo_addr[rd_ptr_q];
                    ram_din  <= fifo_data[rd_ptr_q];
                end
                default: ;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_level <= level_nxt;

            if (grant == SLOT_RD) begin
                rd_wait_q <= 1'b0;
            end else if (rd_miss) begin
                rd_wait_q <= 1'b1;
            end
            if (rd_miss) begin
                rd_addr_q <= cpu_addr;
            end
            rd_pending_q <= rd_pending_nxt;

            vid_valid <= (slot_d1_q == SLOT_VID);
            if (slot_d1_q == SLOT_VID) begin
                vid_dout <= ram_dout;
            end

            cpu_rdy <= 1'b0;
            if (rd_accept && fwd_hit) begin
                cpu_rdy  <= 1'b1;
                cpu_dout <= fwd_data;
            end else if (slot_d1_q == SLOT_RD) begin
                cpu_rdy  <= 1'b1;
                cpu_dout <= ram_dout;
            end

            if (cpu_wr && full) begin
                wovf <= 1'b1;
            end
            cpu_busy <= (level_nxt == LVL_W'(FIFO_DEPTH)) | rd_pending_nxt;
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous screen RAM (14-bit page plus page-select bit, 32 KB) between three requesters: the video fetch engine, CPU reads and CPU writes.
- Video fetches have absolute priority and fixed latency, so pixel/attribute timing stays exact.
- CPU writes are absorbed by a posted-write FIFO with read-after-write forwarding.
- Sits between the video controller / CPU bus decode and the dual-page VRAM.

Parameters:
- FIFO_DEPTH, 4: posted-write FIFO entries; power of 2, range 2..16.
- LVL_W, 3: width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- clk_sys  in  1  master clock; all logic on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- vid_req  in  1  video fetch request, one-cycle pulse.
- vid_addr  in  15  video fetch address, valid with vid_req.
- vid_dout  out  8  fetched byte.
- vid_valid  out  1  one-cycle pulse, vid_dout valid.
- cpu_wr  in  1  CPU write request, one-cycle pulse.
- cpu_rd  in  1  CPU read request, one-cycle pulse.
- cpu_addr  in  15  CPU address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- cpu_rdy  out  1  one-cycle pulse, cpu_dout valid.
- cpu_busy  out  1  FIFO full OR read pending; CPU must not issue new requests while high.
- ram_addr  out  15  RAM address, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_din  out  8  RAM write data, registered.
- ram_dout  in  8  RAM read data, valid one clock after ram_addr.
- fifo_level  out  LVL_W  current FIFO occupancy.
- wovf  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (nRESET low, asynchronous):
  - FIFO emptied; any pending read dropped; slot state = IDLE.
  - All outputs 0, including ram_we, vid_valid, cpu_rdy, wovf and fifo_level.
- Slot scheduler: one RAM slot per clk_sys. Grant is decided from requests sampled at cycle N; RAM signals are registered at edge N+1. Priority order:
  1. Pending vid_req.
  2. FIFO drain, only when FIFO is full.
  3. Pending CPU read.
  4. FIFO drain, when FIFO is non-empty.
  5. IDLE.
- Slot states: IDLE, VID, RD, WR. State is registered, with ram_we=1 only in WR.
- Video path:
  - VID slot at N+1; ram_dout sampled at N+2.
  - vid_dout/vid_valid registered at N+3, giving fixed latency 3.
  - vid_req is never delayed or dropped.
  - Back-to-back vid_req in consecutive cycles is supported (pipelined).
- CPU write:
  - Accepted when cpu_wr=1 and the registered full flag=0; pushed at that edge.
  - cpu_wr while full is dropped and sets wovf. A drain in the same cycle does NOT make room.
  - Drain pops the oldest entry in order and performs one RAM write per WR slot.
- CPU read:
  - Accepted when cpu_rd=1 and no read is pending; cpu_rd while pending is ignored.
  - Forwarding is checked at acceptance against all FIFO entries, plus a write accepted in the same cycle:
    - Hit: the newest matching entry's data appears on cpu_dout with cpu_rdy 1 cycle after acceptance; no RAM slot is used.
    - Miss: read waits for an RD slot; cpu_rdy is registered 2 cycles after the RD slot (slot, RAM data, output).
- Same-cycle cpu_wr and cpu_rd: the write is enqueued first and the read observes it.
- FIFO pointers: wrap modulo FIFO_DEPTH. Full/empty come from the LVL_W-bit level counter. Simultaneous push and pop leaves the level unchanged.
- cpu_busy = full | rd_pending (registered).

Test Plan:
- Reset mid-operation: fill FIFO with 3 writes, issue a read, assert nRESET low -> fifo_level=0, no ram_we, no cpu_rdy, all outputs 0 immediately.
- Video latency: vid_req with vid_addr=0x1800 while RAM[0x1800]=0xA5, during CPU traffic -> vid_valid exactly 3 cycles later with vid_dout=0xA5. 8 consecutive vid_req -> 8 consecutive vid_valid.
- FIFO full/overflow (FIFO_DEPTH=4): hold vid_req high continuously, issue 5 writes -> level 4, cpu_busy=1, 5th dropped, wovf=1. Release vid_req -> 4 in-order ram_we pulses.
- Forwarding: write 0x4000<=0x11 then 0x4000<=0x22 while video blocks draining, then read 0x4000 -> cpu_rdy 1 cycle later, cpu_dout=0x22, no RD slot issued.
- Read miss under contention: read 0x0100 (RAM=0x5A) while vid_req arrives the same cycle -> VID slot first, RD next, cpu_rdy 2 cycles after RD with cpu_dout=0x5A.
- Same-cycle write+read: cpu_wr 0x0200<=0x77 and cpu_rd 0x0200 together -> forwarded 0x77; RAM later holds 0x77.
